// File: rtl/dmem_responder_if.sv
// Request/response bundle for dmem_responder.
// DMEM_RESPONDER_ERR_EN adds the response error flag.
interface dmem_responder_if;
  logic        io_dmemReq_valid;
  logic        io_dmemReq_ready;
  logic [31:0] io_dmemReq_bits_addrRequest;
  logic [31:0] io_dmemReq_bits_dataRequest;
  logic [3:0]  io_dmemReq_bits_activeByteLane;
  logic        io_dmemReq_bits_isWrite;
  logic        io_dmemRsp_valid;
  logic        io_dmemRsp_ready;
  logic [31:0] io_dmemRsp_bits_dataResponse;
`ifdef DMEM_RESPONDER_ERR_EN
  logic        io_dmemRsp_bits_error;
`endif

  modport slave (
    input  io_dmemReq_valid, io_dmemReq_bits_addrRequest, io_dmemReq_bits_dataRequest,
           io_dmemReq_bits_activeByteLane, io_dmemReq_bits_isWrite, io_dmemRsp_ready,
    output io_dmemReq_ready, io_dmemRsp_valid, io_dmemRsp_bits_dataResponse
`ifdef DMEM_RESPONDER_ERR_EN
   ,output io_dmemRsp_bits_error
`endif
  );

  modport master (
    output io_dmemReq_valid, io_dmemReq_bits_addrRequest, io_dmemReq_bits_dataRequest,
           io_dmemReq_bits_activeByteLane, io_dmemReq_bits_isWrite, io_dmemRsp_ready,
    input  io_dmemReq_ready, io_dmemRsp_valid, io_dmemRsp_bits_dataResponse
`ifdef DMEM_RESPONDER_ERR_EN
   ,input  io_dmemRsp_bits_error
`endif
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data memory responder with fixed response latency.
// Optional DMEM_RESPONDER_ERR_EN flags out-of-range addresses instead of wrapping.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic             clock,
  input  logic             reset,
  dmem_responder_if.slave  dmem
);
  localparam int         AW    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_L = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          ready_q;
  logic          rsp_valid_q;
  logic [31:0]   rdata_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    lanes_q;
  logic          wr_q;
  logic          oor_q;
  logic          oor_in;
  logic [31:0]   mem_q [DEPTH_WORDS];
  logic          accept;
  logic          mem_op;

  assign accept = ready_q && dmem.io_dmemReq_valid;
  // The memory access happens on the edge that moves BUSY into RESP.
  assign mem_op = (state_q == BUSY) && (cnt_q == 4'd0);

`ifdef DMEM_RESPONDER_ERR_EN
  logic err_q;
  logic unused_addr;
  assign oor_in      = |dmem.io_dmemReq_bits_addrRequest[31:AW+2];
  assign unused_addr = ^dmem.io_dmemReq_bits_addrRequest[1:0];
  assign dmem.io_dmemRsp_bits_error = err_q;
`else
  logic unused_addr;
  assign oor_in      = 1'b0;
  assign unused_addr = ^{dmem.io_dmemReq_bits_addrRequest[1:0],
                         dmem.io_dmemReq_bits_addrRequest[31:AW+2]};
`endif

  assign dmem.io_dmemReq_ready             = ready_q;
  assign dmem.io_dmemRsp_valid             = rsp_valid_q;
  assign dmem.io_dmemRsp_bits_dataResponse = rdata_q;

  // Request capture: only the accepting edge loads these, later input changes are ignored.
  always_ff @(posedge clock) begin
    if (accept) begin
      idx_q   <= dmem.io_dmemReq_bits_addrRequest[AW+1:2];
      wdata_q <= dmem.io_dmemReq_bits_dataRequest;
      lanes_q <= dmem.io_dmemReq_bits_activeByteLane;
      wr_q    <= dmem.io_dmemReq_bits_isWrite;
      oor_q   <= oor_in;
    end
  end

  // Memory is never reset; an async reset forces IDLE so an aborted write never lands.
  always_ff @(posedge clock) begin
    if (mem_op && wr_q && !oor_q) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
`ifdef DMEM_RESPONDER_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            ready_q <= 1'b0;
            state_q <= BUSY;
            cnt_q   <= LAT_L;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rdata_q     <= (wr_q || oor_q) ? 32'd0 : mem_q[idx_q];
`ifdef DMEM_RESPONDER_ERR_EN
            err_q       <= oor_q;
`endif
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (dmem.io_dmemRsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
`ifdef DMEM_RESPONDER_ERR_EN
            err_q       <= 1'b0;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=1 and LATENCY=0 instances side by side.
module tb_dmem_responder;
`ifdef DMEM_RESPONDER_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_data  [2];
  logic [3:0]  req_lanes [2];
  logic        req_wr    [2];
  logic        rsp_ready [2];
  logic        req_ready_w [2];
  logic        rsp_valid_w [2];
  logic [31:0] rsp_data_w  [2];
  logic        rsp_err_w   [2];

  dmem_responder_if if0 ();
  dmem_responder_if if1 ();

  assign if0.io_dmemReq_valid               = req_valid[0];
  assign if0.io_dmemReq_bits_addrRequest    = req_addr[0];
  assign if0.io_dmemReq_bits_dataRequest    = req_data[0];
  assign if0.io_dmemReq_bits_activeByteLane = req_lanes[0];
  assign if0.io_dmemReq_bits_isWrite        = req_wr[0];
  assign if0.io_dmemRsp_ready               = rsp_ready[0];
  assign if1.io_dmemReq_valid               = req_valid[1];
  assign if1.io_dmemReq_bits_addrRequest    = req_addr[1];
  assign if1.io_dmemReq_bits_dataRequest    = req_data[1];
  assign if1.io_dmemReq_bits_activeByteLane = req_lanes[1];
  assign if1.io_dmemReq_bits_isWrite        = req_wr[1];
  assign if1.io_dmemRsp_ready               = rsp_ready[1];
  assign req_ready_w[0] = if0.io_dmemReq_ready;
  assign req_ready_w[1] = if1.io_dmemReq_ready;
  assign rsp_valid_w[0] = if0.io_dmemRsp_valid;
  assign rsp_valid_w[1] = if1.io_dmemRsp_valid;
  assign rsp_data_w[0]  = if0.io_dmemRsp_bits_dataResponse;
  assign rsp_data_w[1]  = if1.io_dmemRsp_bits_dataResponse;
`ifdef DMEM_RESPONDER_ERR_EN
  assign rsp_err_w[0]   = if0.io_dmemRsp_bits_error;
  assign rsp_err_w[1]   = if1.io_dmemRsp_bits_error;
`else
  assign rsp_err_w[0]   = 1'b0;
  assign rsp_err_w[1]   = 1'b0;
`endif

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (.clock(clk), .reset(rst), .dmem(if0));
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (.clock(clk), .reset(rst), .dmem(if1));

  typedef struct {
    int          sel;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  lanes;
    int          stall;
    logic [31:0] exp;
    bit          exp_err;
  } vec_t;

  vec_t vecs [15];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Caller sits just after a negedge; returns just after the negedge following the handshake.
  task automatic txn(input vec_t v, input string nm);
    int s;
    int n;
    int lat;
    logic [31:0] held;
    s = v.sel;
    req_addr[s]  = v.addr;
    req_data[s]  = v.data;
    req_lanes[s] = v.lanes;
    req_wr[s]    = v.wr;
    req_valid[s] = 1'b1;
    n = 0;
    while (!req_ready_w[s] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, " accept_timeout"}, 32'(n < 20), 32'd1);
    @(posedge clk);
    #1;
    req_valid[s] = 1'b0;
    req_addr[s]  = $urandom;
    req_data[s]  = $urandom;
    req_lanes[s] = 4'($urandom);
    req_wr[s]    = 1'($urandom);
    lat = 0;
    @(negedge clk);
    while (!rsp_valid_w[s] && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check({nm, " latency"}, 32'(lat), (s == 1) ? 32'd2 : 32'd1);
    check({nm, " data"}, rsp_data_w[s], v.exp);
    check({nm, " ready_busy"}, 32'(req_ready_w[s]), 32'd0);
    if (ERR) check({nm, " error"}, 32'(rsp_err_w[s]), 32'(v.exp_err));
    held = rsp_data_w[s];
    for (int k = 0; k < v.stall; k++) begin
      @(negedge clk);
      check({nm, " stall_valid"}, 32'(rsp_valid_w[s]), 32'd1);
      check({nm, " stall_data"}, rsp_data_w[s], held);
      check({nm, " stall_ready"}, 32'(req_ready_w[s]), 32'd0);
    end
    rsp_ready[s] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[s] = 1'b0;
    @(negedge clk);
    check({nm, " valid_drop"}, 32'(rsp_valid_w[s]), 32'd0);
    check({nm, " ready_back"}, 32'(req_ready_w[s]), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_addr[i] = '0; req_data[i] = '0;
      req_lanes[i] = '0;   req_wr[i] = 1'b0; rsp_ready[i] = 1'b0;
    end

    vecs[0]  = '{1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'b1111, 0, 32'h0, 1'b0};
    vecs[1]  = '{1, 1'b0, 32'h0000_0040, 32'h0,         4'b0000, 0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1, 1'b1, 32'h0000_0040, 32'h1122_3344, 4'b0101, 0, 32'h0, 1'b0};
    vecs[3]  = '{1, 1'b0, 32'h0000_0040, 32'h0,         4'b1111, 0, 32'hDE22_BE44, 1'b0};
    vecs[4]  = '{1, 1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'b0000, 0, 32'h0, 1'b0};
    vecs[5]  = '{1, 1'b0, 32'h0000_0043, 32'h0,         4'b0000, 5, 32'hDE22_BE44, 1'b0};
    vecs[6]  = '{1, 1'b1, 32'h0000_0080, 32'hAAAA_5555, 4'b1111, 0, 32'h0, 1'b0};
    vecs[7]  = '{1, 1'b0, 32'h0000_1080, 32'h0,         4'b0000, 0,
                 ERR ? 32'h0 : 32'hAAAA_5555, ERR};
    vecs[8]  = '{0, 1'b1, 32'h0000_0040, 32'h0A0B_0C0D, 4'b1111, 0, 32'h0, 1'b0};
    vecs[9]  = '{0, 1'b0, 32'h1000_0040, 32'h0,         4'b1111, 0,
                 ERR ? 32'h0 : 32'h0A0B_0C0D, ERR};
    vecs[10] = '{0, 1'b1, 32'h0000_007C, 32'h0101_0101, 4'b1111, 0, 32'h0, 1'b0};
    vecs[11] = '{0, 1'b1, 32'h1000_007C, 32'h7777_7777, 4'b1111, 0, 32'h0, ERR};
    vecs[12] = '{0, 1'b0, 32'h0000_007C, 32'h0,         4'b0000, 0,
                 ERR ? 32'h0101_0101 : 32'h7777_7777, 1'b0};
    vecs[13] = '{0, 1'b1, 32'h0000_007C, 32'hAABB_CCDD, 4'b1010, 2, 32'h0, 1'b0};
    vecs[14] = '{0, 1'b0, 32'h0000_007E, 32'h0,         4'b0001, 0,
                 ERR ? 32'hAA01_CC01 : 32'hAA77_CC77, 1'b0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst%0d valid", i), 32'(rsp_valid_w[i]), 32'd0);
      check($sformatf("rst%0d data", i), rsp_data_w[i], 32'd0);
      check($sformatf("rst%0d ready", i), 32'(req_ready_w[i]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("rel1 ready", 32'(req_ready_w[1]), 32'd1);
    check("rel0 ready", 32'(req_ready_w[0]), 32'd1);

    for (int i = 0; i < 15; i++) txn(vecs[i], $sformatf("vec%0d", i));

    // Write aborted by reset while BUSY on the LATENCY=1 instance.
    req_addr[1] = 32'h0000_0080; req_data[1] = 32'h1234_5678;
    req_lanes[1] = 4'b1111;      req_wr[1] = 1'b1; req_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    rst = 1'b1;
    #1;
    check("abort valid", 32'(rsp_valid_w[1]), 32'd0);
    check("abort ready", 32'(req_ready_w[1]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("abort hold_valid", 32'(rsp_valid_w[1]), 32'd0);
    check("abort hold_data", rsp_data_w[1], 32'd0);
    rst = 1'b0;
    #1;
    check("abort ready_pre", 32'(req_ready_w[1]), 32'd0);
    @(negedge clk);
    check("abort ready_post", 32'(req_ready_w[1]), 32'd1);
    txn('{1, 1'b0, 32'h0000_0080, 32'h0, 4'b0000, 0, 32'hAAAA_5555, 1'b0}, "abort read");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
